qoa_mac_sequencer: RTL
======================

# qoa_mac_sequencer

Sequences the shared 16×16 multiplier and the shared 32-bit adder to compute the QOA LMS prediction for one sample: four signed history × weight products, accumulated in 32 bits, then arithmetically shifted right. The block owns adder arbitration. The multiplier uses the adder for its partial sums while a product is in flight. The sequencer takes the adder for one accumulate cycle per tap. The block sits between the decode control FSM, which issues `start`, and the arithmetic unit.

## Interface
Parameters:
- `FRAC_SHIFT`, 13: arithmetic right shift applied to the final accumulator.
- `TIMEOUT`, 40: maximum number of MUL_WAIT cycles before abort. Legal range 2..63.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a prediction; sampled only in IDLE.
- `hist`  in  64  four signed 16-bit history samples; tap i is `hist[16i+15:16i]`. Must be held stable while `busy`.
- `weight`  in  64  four signed 16-bit weights, packed the same way as `hist`. Must be held stable while `busy`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; `pred` is valid in the same cycle.
- `pred`  out  32  signed result, `acc >>> FRAC_SHIFT`; holds its value until the next `done`.
- `err`  out  1  sticky timeout flag; cleared when the next `start` is accepted.
- `mul_restart`  out  1  one-cycle active-high restart pulse to the multiplier.
- `mul_a`, `mul_b`  out  16 each  multiplier operands (current tap's hist and weight).
- `mul_done`  in  1  multiplier result valid.
- `mul_result`  in  32  signed product.
- `add_sel`  out  1  adder input select: 0 = multiplier owns the adder, 1 = sequencer owns it.
- `seq_term1`, `seq_term2`  out  32 each  adder inputs presented when `add_sel` = 1.
- `add_sum`  in  32  adder output (combinational, wraps mod 2^32).

## Operation
- State is a 3-bit FSM: IDLE, MUL_START, MUL_WAIT, ACC, FINISH.
- Other registers: tap counter (2 bits), 32-bit accumulator `acc`, 6-bit watchdog counter `wd`.
- Reset values: state IDLE, tap 0, `acc` 0, `wd` 0, `pred` 0, `err` 0.
- All outputs are 0 in reset, including `add_sel`; the multiplier owns the adder by default.
- IDLE:
  - If `start`: clear `acc`, tap and `err`, then go to MUL_START.
  - Otherwise stay in IDLE.
- MUL_START:
  - Drive `mul_restart` = 1 and `mul_a`/`mul_b` = tap operands.
  - Clear `wd`, go to MUL_WAIT.
- MUL_WAIT:
  - Operands stay driven and `add_sel` = 0.
  - If `mul_done`, go to ACC.
  - Else if `wd` == TIMEOUT−1: set `err` and go to IDLE. There is no `done` pulse and `pred` is unchanged.
  - Else increment `wd`.
- ACC:
  - Drive `add_sel` = 1, `seq_term1` = `acc`, `seq_term2` = `mul_result`; latch `acc` ← `add_sum`.
  - If tap == 3: latch `pred` ← `add_sum >>> FRAC_SHIFT` (sign-preserving), go to FINISH.
  - Else increment tap, go to MUL_START.
- FINISH: `done` = 1, go to IDLE.
- `mul_done` is ignored outside MUL_WAIT.
- `start` is ignored outside IDLE. A `start` in the FINISH cycle is dropped; it is accepted the following cycle if still high.
- Accumulation wraps mod 2^32; there is no saturation. The decoder clamps downstream.
- `seq_term1`/`seq_term2` are 0 when `add_sel` = 0.
- `mul_a`/`mul_b` are 0 in IDLE.
- Asserting `rst_n` low mid-operation returns the block to the reset values immediately.

## Timing
- Let L ≥ 1 be the number of cycles from the `mul_restart` cycle to the first cycle in which `mul_done` is high.
- Cycle 0 is the `start` sampled in IDLE.
- Tap k: MUL_START in cycle 1+k(L+2), ACC in cycle 2+L+k(L+2).
- `done` (FINISH) in cycle 4L+9; `busy` is high from cycle 1 through 4L+9 inclusive.
- `add_sel` is high exactly 4 cycles per completed prediction.
- Timeout: `err` rises TIMEOUT+1 cycles after the MUL_START cycle; `busy` drops in the same cycle.

## Test plan
- Reset and idle:
  - Stimulus: hold `rst_n` = 0, then release with no `start`.
  - Required: all outputs 0 throughout; no `mul_restart`.
- Unity weights:
  - Stimulus: hist = {100, 200, −300, 400}, all weights 8192, L = 3.
  - Required: `pred` = 400, `done` exactly in cycle 21, four `mul_restart` pulses, `add_sel` high for 4 cycles total.
- Sign and shift:
  - Stimulus: hist0 = −1, weight0 = 4096, all other taps 0.
  - Required: `pred` = −1 (arithmetic floor). With hist0 = +1 instead, `pred` = 0.
- Wrap-around:
  - Stimulus: every hist and weight = −32768.
  - Required: `acc` wraps to 0 and `pred` = 0, with no error.
- Timeout:
  - Stimulus: multiplier model never asserts `mul_done`.
  - Required: `err` = 1 and `busy` = 0 at cycle 42, no `done`, `pred` unchanged.
  - Follow-up: the next accepted `start` clears `err`.
- Start while busy and async reset:
  - Stimulus: pulse `start` during MUL_WAIT of tap 1.
  - Required: ignored, single `done`.
  - Stimulus: pull `rst_n` low during ACC of tap 2.
  - Required: immediate return to IDLE with `acc`, `pred`, `add_sel` = 0.

Source files
------------

// File: rtl/qoa_mac_sequencer_if.sv
// Bus between the prediction sequencer and the shared multiplier/adder unit.
// The sequencer drives the master side and the arithmetic unit drives the slave side.
interface qoa_mac_sequencer_if;
  // Handshake: mul_restart is a one-cycle pulse that launches a product of mul_a*mul_b.
  // The product is taken from mul_result on the first cycle that mul_done is high.
  // add_sel=1 hands the adder to the sequencer (seq_term1+seq_term2 -> add_sum).
  // add_sel=0 leaves the adder with the multiplier, and both terms are then 0.
  logic        mul_restart;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_done;
  logic [31:0] mul_result;
  logic        add_sel;
  logic [31:0] seq_term1;
  logic [31:0] seq_term2;
  logic [31:0] add_sum;

  modport master (
    output mul_restart, mul_a, mul_b, add_sel, seq_term1, seq_term2,
    input  mul_done, mul_result, add_sum
  );

  modport slave (
    input  mul_restart, mul_a, mul_b, add_sel, seq_term1, seq_term2,
    output mul_done, mul_result, add_sum
  );
endinterface

// File: rtl/qoa_mac_sequencer.sv
// QOA LMS prediction: four signed hist*weight taps through the shared multiplier,
// accumulated on the shared adder, then arithmetically shifted by FRAC_SHIFT.
module qoa_mac_sequencer #(
  parameter int FRAC_SHIFT = 13,
  parameter int TIMEOUT    = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [63:0]           hist,
  input  logic [63:0]           weight,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           pred,
  output logic                  err,
  qoa_mac_sequencer_if.master   arith,
  output logic [2:0]            state_dbg,
  output logic [31:0]           acc_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MUL_START = 3'd1,
    S_MUL_WAIT  = 3'd2,
    S_ACC       = 3'd3,
    S_FINISH    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  tap_q, tap_d;
  logic [31:0] acc_q, acc_d;
  logic [5:0]  wd_q, wd_d;
  logic [31:0] pred_q, pred_d;
  logic        err_q, err_d;

  logic [15:0]        tap_hist;
  logic [15:0]        tap_weight;
  logic signed [31:0] sum_s;

  assign tap_hist   = hist[{tap_q, 4'b0000} +: 16];
  assign tap_weight = weight[{tap_q, 4'b0000} +: 16];
  assign sum_s      = arith.add_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tap_q   <= 2'd0;
      acc_q   <= 32'd0;
      wd_q    <= 6'd0;
      pred_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      acc_q   <= acc_d;
      wd_q    <= wd_d;
      pred_q  <= pred_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    acc_d   = acc_q;
    wd_d    = wd_q;
    pred_d  = pred_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = 32'd0;
          tap_d   = 2'd0;
          err_d   = 1'b0;
          state_d = S_MUL_START;
        end
      end
      S_MUL_START: begin
        wd_d    = 6'd0;
        state_d = S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        // A stalled multiplier aborts the sample; pred keeps the last good value.
        if (arith.mul_done) begin
          state_d = S_ACC;
        end else if (wd_q == 6'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 6'd1;
        end
      end
      S_ACC: begin
        acc_d = arith.add_sum;
        if (tap_q == 2'd3) begin
          pred_d  = sum_s >>> FRAC_SHIFT;
          state_d = S_FINISH;
        end else begin
          tap_d   = tap_q + 2'd1;
          state_d = S_MUL_START;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy              = (state_q != S_IDLE);
    done              = (state_q == S_FINISH);
    pred              = pred_q;
    err               = err_q;
    arith.mul_restart = (state_q == S_MUL_START);
    arith.mul_a       = busy ? tap_hist : 16'd0;
    arith.mul_b       = busy ? tap_weight : 16'd0;
    arith.add_sel     = (state_q == S_ACC);
    arith.seq_term1   = arith.add_sel ? acc_q : 32'd0;
    arith.seq_term2   = arith.add_sel ? arith.mul_result : 32'd0;
    state_dbg         = state_q;
    acc_dbg           = acc_q;
  end

endmodule
